// File: rtl/alu_pkg.sv
// Shared definitions for the simple_alu command path:
// opcodes, flag bit positions and sequencer states.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for simple_alu: accept, pulse execute, wait for
// done (or watchdog expiry), then hold the response until taken.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [3:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    output logic             alu_execute,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    input  logic             alu_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout,
    output logic             busy,
    output logic [7:0]       timeout_count
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    seq_state_e state;
    seq_state_e state_nxt;
    logic [CW-1:0] wd_cnt;
    logic accept;
    logic wd_hit;

    // Gated by rst_n so the port reads 0 while reset is held.
    assign cmd_ready   = rst_n && (state == IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign wd_hit      = (wd_cnt == WD_LAST);
    assign alu_execute = (state == ISSUE);
    assign rsp_valid   = (state == RESP);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (alu_done || wd_hit) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_opcode    <= '0;
            rsp_tag       <= '0;
            rsp_result    <= '0;
            rsp_flags     <= '0;
            rsp_timeout   <= 1'b0;
            timeout_count <= '0;
            wd_cnt        <= '0;
        end else begin
            if (accept) begin
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
                alu_opcode <= cmd_op;
                rsp_tag    <= cmd_tag;
            end
            if (state == ISSUE) begin
                wd_cnt <= '0;
            end
            // done wins over a watchdog expiry in the same cycle
            if (state == WAIT) begin
                if (alu_done) begin
                    rsp_result  <= alu_result;
                    rsp_flags   <= alu_flags;
                    rsp_timeout <= 1'b0;
                end else if (wd_hit) begin
                    rsp_result  <= '0;
                    rsp_flags   <= '0;
                    rsp_timeout <= 1'b1;
                    if (timeout_count != 8'hFF) begin
                        timeout_count <= timeout_count + 8'd1;
                    end
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream command front-end for `simple_alu`. It accepts operand/opcode commands over a valid/ready handshake and drives the ALU's edge-triggered `execute`. It waits for the ALU's one-cycle `done` pulse, captures `result`/`flags`, and returns them with the command tag over a second valid/ready handshake. A timeout watchdog guarantees a response even if `done` never arrives.

## Interface
- `WIDTH`, 8, operand/result width; must match the ALU.
- `TIMEOUT`, 15, maximum cycles spent in WAIT before a forced response; must be ≥1.
- `TAG_W`, 4, command tag width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_a`, `cmd_b`  in  WIDTH  operands.
- `cmd_op`  in  4  ALU opcode.
- `cmd_tag`  in  TAG_W  opaque ID, echoed on the response.
- `alu_a`, `alu_b`  out  WIDTH  operands to the ALU.
- `alu_opcode`  out  4  opcode to the ALU.
- `alu_execute`  out  1  one-cycle execute pulse.
- `alu_result`  in  WIDTH  ALU result.
- `alu_flags`  in  4  ALU flags {Z,N,C,V}.
- `alu_done`  in  1  ALU completion pulse.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_flags`  out  4  captured flags.
- `rsp_tag`  out  TAG_W  echoed tag.
- `rsp_timeout`  out  1  response was forced by the watchdog.
- `busy`  out  1  state ≠ IDLE.
- `timeout_count`  out  8  saturating count of timeouts.

## Operation
- **FSM states:** IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE:**
  - `cmd_ready=1`.
  - On `cmd_valid&&cmd_ready`: register `cmd_a`, `cmd_b`, `cmd_op`, `cmd_tag` into the `alu_*` outputs and the tag register; go to ISSUE.
- **ISSUE** (exactly one cycle):
  - `alu_execute=1`.
  - Clear the watchdog counter; go to WAIT.
- **WAIT:**
  - `alu_execute=0`.
  - If `alu_done=1`: capture `alu_result`/`alu_flags` into `rsp_result`/`rsp_flags`, set `rsp_timeout=0`, go to RESP.
  - Else, if counter == TIMEOUT−1: set `rsp_result=0`, `rsp_flags=0`, `rsp_timeout=1`, increment `timeout_count` (saturating at 255), go to RESP.
  - Else increment the counter.
  - `done` takes priority over timeout in the same cycle.
- **RESP:**
  - `rsp_valid=1`; all `rsp_*` outputs held stable.
  - On `rsp_ready`: go to IDLE.
- **Hold and opcodes:**
  - `alu_a`/`alu_b`/`alu_opcode` hold their values from ISSUE until the next accept.
  - Opcodes are forwarded unchecked; an undefined opcode simply returns what the ALU returns.
- **Ignored `alu_done`:** a pulse in IDLE, ISSUE or RESP is ignored and has no side effects.
- **Execute pulse guarantee:** `alu_execute` is low for at least one cycle between pulses (WAIT is always ≥1 cycle), so the ALU always sees a rising edge.
- **Counter width:** watchdog counter is `$clog2(TIMEOUT+1)` bits.

## Timing
- **Reset:**
  - State IDLE.
  - `cmd_ready=0` while `rst_n` is low, 1 in the first cycle after release.
  - All other outputs 0: `alu_a`, `alu_b`, `alu_opcode`, `alu_execute`, `rsp_valid`, `rsp_result`, `rsp_flags`, `rsp_tag`, `rsp_timeout`, `busy`, `timeout_count`.
- **Normal latency** (accept at cycle 0): `alu_execute` high in cycle 1; ALU `done` in cycle 2; `rsp_valid` from cycle 3.
- **Throughput:** minimum 4 cycles per command with `rsp_ready` tied high; next accept in cycle 4.
- **Timeout latency:** `rsp_valid` rises at cycle TIMEOUT+2 after accept (WAIT lasts TIMEOUT cycles).
- **Back-pressure:**
  - With `rsp_ready=0`, stay in RESP indefinitely; `rsp_*` outputs stable, `cmd_ready=0`.
  - `cmd_ready` is registered-state derived, with no combinational path from `rsp_ready`.
- **Reset mid-operation:** immediate return to IDLE with all outputs at reset values; an in-flight command is dropped with no response.

## Structure
- **Shared package `alu_pkg`:**
  - Opcode constants (ADD=0 … MUL=9).
  - Flag indices (Z=3, N=2, C=1, V=0).
  - FSM state enum (IDLE=0, ISSUE=1, WAIT=2, RESP=3).
- **No sub-module:** the FSM, watchdog and capture registers live in one module.
- **Testbench:** instantiates `simple_alu` with the same WIDTH.

## Test plan
- **ADD:** cmd `a=8'h0F`, `b=8'h01`, `op=0`, `tag=4'h5`, `rsp_ready=1` → `rsp_valid` at cycle 3, `rsp_result=8'h10`, `rsp_tag=5`, `rsp_timeout=0`, `cmd_ready` back at cycle 4.
- **Back-to-back:** AND `8'hF0&8'h3C` then XOR `8'hFF^8'h0F`, `cmd_valid` held high → results `8'h30` then `8'hF0`, accepts 4 cycles apart, exactly one `alu_execute` pulse each.
- **Back-pressure:** `rsp_ready=0` for 6 cycles after `rsp_valid` → outputs stable, `cmd_ready=0`, `busy=1`; release → handshake, IDLE next cycle.
- **Timeout:** `alu_done` forced to 0, TIMEOUT=15 → `rsp_valid` at cycle 17, `rsp_timeout=1`, result/flags 0, `timeout_count=1`; repeat 256 times → count saturates at 255.
- **Spurious done:** `alu_done` pulsed in IDLE and in RESP → no state change, response unchanged.
- **Reset mid-WAIT:** assert `rst_n=0` in cycle 2 → all outputs 0, no response; a new command after release completes normally.
